// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU with IDLE/RUN/DONE sequencing

module alu_serial_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_XNOR  = 4'b0110;
   localparam logic [3:0] OP_NAND  = 4'b0111;
   localparam logic [3:0] OP_PASSA = 4'b1000;
   localparam logic [3:0] OP_PASSB = 4'b1001;
   localparam logic [3:0] OP_ZERO  = 4'b1010;
   localparam logic [3:0] OP_SLT   = 4'b1011;
   localparam logic [3:0] OP_SLTU  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;

   logic a_bit;
   logic b_bit;
   logic sum_bit;
   logic cy_bit;
   logic bit_out;
   logic arith;
   logic lt_bit;

   // Subtract-style ops run as A + ~B + 1: B inverted, carry seeded with 1
   function automatic logic is_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   endfunction

   // Single 1-bit slice: full adder plus per-bit logic function on the current bit index
   always_comb begin
      a_bit   = a_q[cnt_q];
      b_bit   = b_q[cnt_q] ^ is_sub(op_q);
      sum_bit = a_bit ^ b_bit ^ carry_q;
      cy_bit  = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
      arith   = (op_q == OP_ADD) || is_sub(op_q);
      lt_bit  = (carry_q ^ cy_bit) ^ sum_bit;
      bit_out = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB, OP_SLT, OP_SLTU: bit_out = sum_bit;
         OP_AND:   bit_out = a_bit & b_bit;
         OP_OR:    bit_out = a_bit | b_bit;
         OP_NOR:   bit_out = ~(a_bit | b_bit);
         OP_XOR:   bit_out = a_bit ^ b_bit;
         OP_XNOR:  bit_out = ~(a_bit ^ b_bit);
         OP_NAND:  bit_out = ~(a_bit & b_bit);
         OP_PASSA: bit_out = a_bit;
         OP_PASSB: bit_out = b_bit;
         OP_ZERO:  bit_out = 1'b0;
         default:  bit_out = 1'b0;
      endcase
   end

   // Next-state logic: acceptance latching, per-bit shifting and final result fix-up
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               op_d    = alu_op;
               a_d     = op_a;
               b_d     = op_b;
               carry_d = is_sub(alu_op);
               cnt_d   = '0;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            carry_d  = cy_bit;
            result_d = {bit_out, result_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               cout_d  = arith ? cy_bit : 1'b0;
               if (op_q == OP_SLT) begin
                  result_d = {{(WIDTH-1){1'b0}}, lt_bit};
               end else if (op_q == OP_SLTU) begin
                  result_d = {{(WIDTH-1){1'b0}}, ~cy_bit};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign cout   = cout_q;

endmodule
